// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared types and line levels for the framed serial transmitter.
//   tx_state_t  : transmitter FSM states
//   IDLE_LEVEL  : level driven on the serial line between frames (and in stop bits)
//   START_LEVEL : level of the start bit
// Optional feature macro: PISO_PARITY_EN (PARITY state used only when defined).
// ---------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/piso_fifo.sv
// ---------------------------------------------------------------------------
// piso_fifo
// Synchronous FIFO buffering parallel words ahead of the serializer.
// Read data is presented combinationally from the head entry (show-ahead),
// so a pop and its data happen in the same cycle.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   wr_en        : write request (ignored when full)
//   wr_data      : word to write
//   rd_en        : pop request (ignored when empty)
//   rd_data      : head-of-queue word
//   full, empty  : status
//   level        : number of stored words (0..FIFO_DEPTH)
// ---------------------------------------------------------------------------
module piso_fifo
    import piso_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  push;
    logic                  pop;

    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        push     = wr_en && !full;
        pop      = rd_en && !empty;
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        level    = wr_ptr_q - rd_ptr_q;
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/piso_frame_serializer.sv
// ---------------------------------------------------------------------------
// piso_frame_serializer
// Parallel-in/serial-out transmitter. Words arrive on a valid/ready stream,
// are buffered in piso_fifo, and are sent as frames:
//   start bit (0), DATA_WIDTH data bits, optional even-parity bit, stop bit(s) (1).
// Each bit is held for CLKS_PER_BIT clocks. Back-to-back frames have no gap.
// Optional feature macro: PISO_PARITY_EN adds the parity bit after the data.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   s_valid     : s_data is valid
//   s_data      : word to transmit
//   s_ready     : buffer can accept a word (not full)
//   srl_out     : registered serial line, idles high
//   tx_active   : high while a frame is on srl_out
//   tx_done     : one-cycle pulse on the last cycle of the final stop bit
//   fifo_level  : words currently buffered
//
// state  | meaning
// IDLE   | line idle; pops the next word as soon as one is buffered
// START  | start bit
// DATA   | data bits, order set by MSB_FIRST
// PARITY | even parity bit (only with PISO_PARITY_EN)
// STOP   | stop bit(s); pops the next word on the last cycle if available
//
// All line-facing outputs are registered from the current state, so srl_out,
// tx_active and tx_done are mutually aligned and lag the FSM by one clock.
// ---------------------------------------------------------------------------
module piso_frame_serializer
    import piso_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          s_ready,
    output logic                          srl_out,
    output logic                          tx_active,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_ONE   = CW'(1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    tx_state_t             state_q, state_d;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  srl_out_q, srl_out_d;
    logic                  tx_active_q, tx_active_d;
    logic                  tx_done_q, tx_done_d;
`ifdef PISO_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic                  bit_end;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    assign s_ready    = !fifo_full;
    assign fifo_push  = s_valid && s_ready;
    assign srl_out    = srl_out_q;
    assign tx_active  = tx_active_q;
    assign tx_done    = tx_done_q;

    piso_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_push),
        .wr_data (s_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        srl_out_d   = IDLE_LEVEL;
        tx_active_d = (state_q != IDLE);
        tx_done_d   = 1'b0;
        fifo_pop    = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d    = parity_q;
`endif
        bit_end     = (clk_cnt_q == CLK_LAST);

        // Divider runs only inside a frame and is back at 0 whenever IDLE is entered.
        if (state_q != IDLE) begin
            clk_cnt_d = bit_end ? '0 : (clk_cnt_q + CLK_ONE);
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                end
            end

            START: begin
                srl_out_d = START_LEVEL;
                if (bit_end) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                srl_out_d = (MSB_FIRST != 0) ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
                if (bit_end) begin
                    shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
`ifdef PISO_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
            end

`ifdef PISO_PARITY_EN
            PARITY: begin
                srl_out_d = parity_q;
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif

            STOP: begin
                srl_out_d = IDLE_LEVEL;
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        tx_done_d = 1'b1;
                        bit_cnt_d = '0;
                        // Chain straight into the next frame when a word is waiting.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            state_d  = START;
                        end else begin
                            state_d  = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The popped word is captured once; later FIFO writes cannot disturb it.
        if (fifo_pop) begin
            shreg_d  = fifo_rd_data;
`ifdef PISO_PARITY_EN
            parity_d = ^fifo_rd_data;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            srl_out_q   <= IDLE_LEVEL;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            srl_out_q   <= srl_out_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
`ifdef PISO_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_frame_serializer
// Reference model: every accepted word becomes a frame whose first line cycle
// is max(accept_edge + 2, previous_frame_end + 1) and which lasts
// (1 + DW + parity + stop) * CPB cycles; the word leaves the buffer one edge
// before its frame starts. Line, tx_active, tx_done, s_ready and fifo_level
// are all derived from that frame list.
// ---------------------------------------------------------------------------
module tb_piso_frame_serializer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int STOPB = 1;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = (1 + DW + PAR + STOPB) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, srl_out, tx_active, tx_done;
    logic [2:0] fifo_level;

    logic       s_valid_m = 1'b0;
    logic [7:0] s_data_m = 8'h00;
    logic       s_ready_m, srl_out_m, tx_active_m, tx_done_m;
    logic [2:0] fifo_level_m;

    always #5 clk = ~clk;

    piso_frame_serializer #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB),
        .STOP_BITS(STOPB), .MSB_FIRST(0)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .srl_out(srl_out), .tx_active(tx_active),
        .tx_done(tx_done), .fifo_level(fifo_level)
    );

    piso_frame_serializer #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB),
        .STOP_BITS(STOPB), .MSB_FIRST(1)
    ) dut_m (
        .clk(clk), .rst(rst), .s_valid(s_valid_m), .s_data(s_data_m),
        .s_ready(s_ready_m), .srl_out(srl_out_m), .tx_active(tx_active_m),
        .tx_done(tx_done_m), .fifo_level(fifo_level_m)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_end = -1000;
    int fr_acc[$];
    int fr_st[$];
    int fr_en[$];
    logic [7:0] fr_w[$];

    function automatic logic frame_bit(logic [7:0] w, int j, bit msb);
        if (j == 0) return 1'b0;
        if (j <= DW) return msb ? w[DW - j] : w[j - 1];
        if (PAR == 1 && j == DW + 1) return ^w;
        return 1'b1;
    endfunction

    function automatic int exp_level(int i);
        int n;
        n = 0;
        foreach (fr_acc[k]) begin
            if (fr_acc[k] <= i) n++;
            if (fr_st[k] - 1 <= i) n--;
        end
        return n;
    endfunction

    function automatic logic [6:0] exp_vec(int i);
        logic line, act, done;
        int lv;
        line = 1'b1; act = 1'b0; done = 1'b0;
        foreach (fr_st[k]) begin
            if (i >= fr_st[k] && i <= fr_en[k]) begin
                line = frame_bit(fr_w[k], (i - fr_st[k]) / CPB, 1'b0);
                act  = 1'b1;
                done = (i == fr_en[k]);
            end
        end
        lv = exp_level(i);
        return {line, act, done, (lv < DEPTH), 3'(lv)};
    endfunction

    task automatic clear_model();
        fr_acc.delete(); fr_st.delete(); fr_en.delete(); fr_w.delete();
        last_end = -1000;
    endtask

    // Advance one clock; the model decides acceptance from its own level.
    task automatic step(output bit acc);
        int st;
        acc = s_valid && !rst && (exp_level(cyc) < DEPTH);
        @(posedge clk);
        cyc++;
        if (acc) begin
            st = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
            fr_acc.push_back(cyc); fr_st.push_back(st);
            fr_en.push_back(st + FL - 1); fr_w.push_back(s_data);
            last_end = st + FL - 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit a;
        @(negedge clk);
        total++;
        if ({srl_out, tx_active, tx_done, s_ready, fifo_level} !== 7'b1001000) begin
            bad++;
            $display("FAIL reset_vals got=%b exp=%b", {srl_out, tx_active, tx_done, s_ready, fifo_level}, 7'b1001000);
        end
        total++;
        if ({srl_out_m, tx_active_m, tx_done_m, s_ready_m, fifo_level_m} !== 7'b1001000) begin
            bad++;
            $display("FAIL reset_vals_m got=%b exp=%b", {srl_out_m, tx_active_m, tx_done_m, s_ready_m, fifo_level_m}, 7'b1001000);
        end
        step(a); step(a);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_idle();
        bit a;
        s_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            s_data = 8'($urandom);
            step(a);
            total++;
            if ({srl_out, tx_active, tx_done, s_ready, fifo_level} !== exp_vec(cyc)) begin
                bad++;
                $display("FAIL wave_idle cyc=%0d got=%b exp=%b", cyc, {srl_out, tx_active, tx_done, s_ready, fifo_level}, exp_vec(cyc));
            end
        end
    endtask

    task automatic test_single();
        bit a;
        int acc_cyc, t0, dn;
        dn = 0; t0 = -1;
        s_valid = 1'b1; s_data = 8'hA5;
        step(a);
        acc_cyc = cyc;
        s_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (k > 0) step(a);
            total++;
            if ({srl_out, tx_active, tx_done, s_ready, fifo_level} !== exp_vec(cyc)) begin
                bad++;
                $display("FAIL wave_single cyc=%0d got=%b exp=%b", cyc, {srl_out, tx_active, tx_done, s_ready, fifo_level}, exp_vec(cyc));
            end
            if (tx_done === 1'b1) dn++;
            if (srl_out === 1'b0 && t0 < 0) t0 = cyc;
        end
        total++;
        if (t0 !== acc_cyc + 2) begin
            bad++;
            $display("FAIL single_start_latency got=%0d exp=%0d", t0 - acc_cyc, 2);
        end
        total++;
        if (dn !== 1) begin
            bad++;
            $display("FAIL single_done_count got=%0d exp=1", dn);
        end
    endtask

    task automatic test_back_to_back();
        bit a;
        int act, dn;
        act = 0; dn = 0;
        s_valid = 1'b1; s_data = 8'h00; step(a);
        s_data = 8'hFF;
        for (int k = 0; k < 92; k++) begin
            step(a);
            s_valid = 1'b0;
            total++;
            if ({srl_out, tx_active, tx_done, s_ready, fifo_level} !== exp_vec(cyc)) begin
                bad++;
                $display("FAIL wave_b2b cyc=%0d got=%b exp=%b", cyc, {srl_out, tx_active, tx_done, s_ready, fifo_level}, exp_vec(cyc));
            end
            if (tx_active === 1'b1) act++;
            if (tx_done === 1'b1) dn++;
        end
        total++;
        if (act !== 2 * FL) begin
            bad++;
            $display("FAIL b2b_active_cycles got=%0d exp=%0d", act, 2 * FL);
        end
        total++;
        if (dn !== 2) begin
            bad++;
            $display("FAIL b2b_done_count got=%0d exp=2", dn);
        end
    endtask

    task automatic test_full();
        bit a, saw;
        int n;
        logic [7:0] wds [6];
        n = 0; saw = 1'b0;
        for (int k = 0; k < 6; k++) wds[k] = 8'($urandom);
        for (int k = 0; k < 600 && !(n == 6 && cyc > last_end + 2); k++) begin
            s_valid = (n < 6);
            s_data  = (n < 6) ? wds[n] : 8'h00;
            step(a);
            if (a) n++;
            total++;
            if ({srl_out, tx_active, tx_done, s_ready, fifo_level} !== exp_vec(cyc)) begin
                bad++;
                $display("FAIL wave_full cyc=%0d got=%b exp=%b", cyc, {srl_out, tx_active, tx_done, s_ready, fifo_level}, exp_vec(cyc));
            end
            if (s_ready === 1'b0 && fifo_level === 3'd4) saw = 1'b1;
        end
        s_valid = 1'b0;
        total++;
        if (n != 6 || cyc <= last_end + 2) begin
            bad++;
            $display("FAIL full_timeout got=%0d words exp=6", n);
        end
        total++;
        if (saw !== 1'b1) begin
            bad++;
            $display("FAIL full_ready_drop got=%0d exp=1", saw);
        end
    endtask

    task automatic test_random();
        bit a;
        int pct;
        for (int blk = 0; blk < 8; blk++) begin
            case ($urandom_range(0, 2))
                0: pct = 2;
                1: pct = 10;
                default: pct = 60;
            endcase
            for (int k = 0; k < 50; k++) begin
                s_valid = ($urandom_range(0, 99) < pct);
                s_data  = 8'($urandom);
                step(a);
                total++;
                if ({srl_out, tx_active, tx_done, s_ready, fifo_level} !== exp_vec(cyc)) begin
                    bad++;
                    $display("FAIL wave_rand cyc=%0d got=%b exp=%b", cyc, {srl_out, tx_active, tx_done, s_ready, fifo_level}, exp_vec(cyc));
                end
            end
        end
        s_valid = 1'b0;
        for (int k = 0; k < 400 && cyc <= last_end + 2; k++) begin
            step(a);
            total++;
            if ({srl_out, tx_active, tx_done, s_ready, fifo_level} !== exp_vec(cyc)) begin
                bad++;
                $display("FAIL wave_drain cyc=%0d got=%b exp=%b", cyc, {srl_out, tx_active, tx_done, s_ready, fifo_level}, exp_vec(cyc));
            end
        end
        total++;
        if (cyc <= last_end + 2) begin
            bad++;
            $display("FAIL rand_drain_timeout got=%0d exp>%0d", cyc, last_end + 2);
        end
    endtask

    task automatic test_msb_first();
        bit a;
        int t, dn, act;
        logic exp_l, in_fr;
        logic [7:0] w;
        dn = 0;
        for (int r = 0; r < 2; r++) begin
            w = (r == 0) ? 8'h81 : 8'h07;
            act = 0;
            s_valid_m = 1'b1; s_data_m = w;
            step(a);
            t = cyc;
            s_valid_m = 1'b0;
            for (int k = 0; k < FL + 6; k++) begin
                step(a);
                in_fr = (cyc >= t + 2) && (cyc <= t + 1 + FL);
                exp_l = in_fr ? frame_bit(w, (cyc - t - 2) / CPB, 1'b1) : 1'b1;
                total++;
                if ({srl_out_m, tx_active_m} !== {exp_l, in_fr}) begin
                    bad++;
                    $display("FAIL wave_msb w=%h cyc=%0d got=%b exp=%b", w, cyc, {srl_out_m, tx_active_m}, {exp_l, in_fr});
                end
                if (tx_done_m === 1'b1) dn++;
                if (tx_active_m === 1'b1) act++;
            end
            total++;
            if (act !== FL) begin
                bad++;
                $display("FAIL msb_frame_len w=%h got=%0d exp=%0d", w, act, FL);
            end
        end
        total++;
        if (dn !== 2) begin
            bad++;
            $display("FAIL msb_done_count got=%0d exp=2", dn);
        end
        total++;
        if ({s_ready_m, fifo_level_m} !== 4'b1000) begin
            bad++;
            $display("FAIL msb_idle_fifo got=%b exp=%b", {s_ready_m, fifo_level_m}, 4'b1000);
        end
    endtask

    task automatic test_reset_mid();
        bit a;
        int target;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 8'($urandom);
            step(a);
        end
        s_valid = 1'b0;
        target = fr_st[fr_st.size() - 3] + 4 * CPB;
        for (int k = 0; k < 200 && cyc < target; k++) begin
            step(a);
            total++;
            if ({srl_out, tx_active, tx_done, s_ready, fifo_level} !== exp_vec(cyc)) begin
                bad++;
                $display("FAIL wave_premid cyc=%0d got=%b exp=%b", cyc, {srl_out, tx_active, tx_done, s_ready, fifo_level}, exp_vec(cyc));
            end
        end
        rst = 1'b1;
        #1;
        total++;
        if ({srl_out, tx_active, tx_done, s_ready, fifo_level} !== 7'b1001000) begin
            bad++;
            $display("FAIL reset_mid got=%b exp=%b", {srl_out, tx_active, tx_done, s_ready, fifo_level}, 7'b1001000);
        end
        clear_model();
        step(a); step(a);
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step(a);
            total++;
            if ({srl_out, tx_active, tx_done, s_ready, fifo_level} !== exp_vec(cyc)) begin
                bad++;
                $display("FAIL wave_postrst cyc=%0d got=%b exp=%b", cyc, {srl_out, tx_active, tx_done, s_ready, fifo_level}, exp_vec(cyc));
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_full();
        test_random();
        test_msb_first();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d exp=finished", cyc);
        $fatal(1);
    end

endmodule
